// File: rtl/dly_pkg.sv
// dly_pkg: shared constants and the delay-to-cycles conversion for dly_timer.
//
// Contents:
//   CLK_HZ_DEFAULT            default system clock (50 MHz)
//   DLY_200NS/DLY_1US/DLY_2_1MS  standard delay presets in ns
//   dly_state_e               IDLE / RUN view of the delay counter
//   dly_cycles()              ns -> clock cycles, rounded to nearest, minimum 1
//
// Build option: DLY_FAST_SIM_EN
//   When defined, dly_cycles() divides its result by 1000 (minimum 1) so
//   millisecond delay chains run quickly in simulation.
package dly_pkg;

    localparam int CLK_HZ_DEFAULT = 50_000_000;

    localparam int DLY_200NS = 200;
    localparam int DLY_1US   = 1000;
    localparam int DLY_2_1MS = 2_100_000;

    typedef enum logic [0:0] {
        DLY_IDLE = 1'b0,
        DLY_RUN  = 1'b1
    } dly_state_e;

    // Cycles for a delay of delay_ns at clk_hz. 64-bit intermediate so that
    // 2.1 ms at 50 MHz (1.05e14 ns*Hz) cannot overflow.
    function automatic int dly_cycles(input longint clk_hz, input longint delay_ns);
        longint prod;
        longint n;
        prod = delay_ns * clk_hz;
        n    = (prod + 64'sd500_000_000) / 64'sd1_000_000_000;
        if (n < 64'sd1) begin
            n = 64'sd1;
        end else begin
            n = n;
        end
`ifdef DLY_FAST_SIM_EN
        n = n / 64'sd1000;
        if (n < 64'sd1) begin
            n = 64'sd1;
        end else begin
            n = n;
        end
`endif
        return int'(n);
    endfunction

endpackage

// File: rtl/dly_timer.sv
// dly_timer: single-shot, retriggerable delay generator.
//
// A trigger on `in` loads a down-counter with N = dly_cycles(CLK_HZ, DELAY_NS);
// `p` pulses for one clock N cycles after the sampling edge, then the block
// returns to idle.
//
// Parameters:
//   CLK_HZ     system clock frequency in Hz
//   DELAY_NS   delay in ns
//   EDGE_TRIG  0: `in` high is a trigger every cycle; 1: only a rising edge
//   RETRIGGER  1: trigger while running reloads; 0: ignored while running
//
// Ports:
//   clk    input   system clock, rising edge
//   reset  input   asynchronous active-low reset
//   in     input   trigger
//   p      output  one-cycle delayed pulse (registered)
//   busy   output  high while a delay is in progress (registered)
//
// Build option: DLY_FAST_SIM_EN (see dly_pkg) shortens N by 1000x.
module dly_timer
    import dly_pkg::*;
#(
    parameter int CLK_HZ    = CLK_HZ_DEFAULT,
    parameter int DELAY_NS  = DLY_1US,
    parameter int EDGE_TRIG = 0,
    parameter int RETRIGGER = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic in,
    output logic p,
    output logic busy
);

    localparam int N  = dly_cycles(longint'(CLK_HZ), longint'(DELAY_NS));
    localparam int CW = $clog2(N + 1);

    localparam logic [CW-1:0] LOAD_VAL = CW'(N);
    localparam logic [CW-1:0] ZERO_VAL = {CW{1'b0}};
    localparam logic [CW-1:0] ONE_VAL  = {{(CW-1){1'b0}}, 1'b1};

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          in_q;
    logic          p_q;
    logic          busy_q;
    logic          trig_s;
    dly_state_e    state_s;

    // Trigger qualification: level, or rising edge against last cycle's `in`
    // (combinational, so edge mode adds no latency).
    always_comb begin
        trig_s = 1'b0;
        if (EDGE_TRIG != 0) begin
            trig_s = in & ~in_q;
        end else begin
            trig_s = in;
        end
    end

    // Decode the counter into the idle/run view used by the next-state logic.
    always_comb begin
        state_s = DLY_IDLE;
        if (cnt_q != ZERO_VAL) begin
            state_s = DLY_RUN;
        end else begin
            state_s = DLY_IDLE;
        end
    end

    // Next count: load/reload wins over decrement; counter stops at zero.
    always_comb begin
        cnt_d = cnt_q;
        case (state_s)
            DLY_IDLE: begin
                if (trig_s) begin
                    cnt_d = LOAD_VAL;
                end else begin
                    cnt_d = ZERO_VAL;
                end
            end
            DLY_RUN: begin
                if (trig_s && (RETRIGGER != 0)) begin
                    cnt_d = LOAD_VAL;
                end else begin
                    cnt_d = cnt_q - ONE_VAL;
                end
            end
            default: begin
                cnt_d = ZERO_VAL;
            end
        endcase
    end

    // State and registered outputs. `p` is high during the cycle in which the
    // counter holds 1, i.e. it is decoded from the next count; a reload on the
    // edge that would have produced 1 therefore suppresses the pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q  <= ZERO_VAL;
            in_q   <= 1'b0;
            p_q    <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            in_q   <= in;
            p_q    <= (cnt_d == ONE_VAL);
            busy_q <= (cnt_d != ZERO_VAL);
        end
    end

    assign p    = p_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_dly_timer.sv
// Directed bench for dly_timer: five instances cover level/edge triggering,
// retrigger on/off, and the long 2.1 ms preset (shortened when
// DLY_FAST_SIM_EN is defined).
module tb_dly_timer;

    logic clk = 1'b0;
    logic reset;
    logic in0 = 1'b0, in1 = 1'b0, in2 = 1'b0, in3 = 1'b0, in4 = 1'b0;
    logic p0, p1, p2, p3, p4;
    logic busy0, busy1, busy2, busy3, busy4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // N = 10, level, retrigger
    dly_timer #(.DELAY_NS(200), .EDGE_TRIG(0), .RETRIGGER(1)) u0 (
        .clk(clk), .reset(reset), .in(in0), .p(p0), .busy(busy0));
    // N = 50, level, retrigger
    dly_timer #(.DELAY_NS(1000), .EDGE_TRIG(0), .RETRIGGER(1)) u1 (
        .clk(clk), .reset(reset), .in(in1), .p(p1), .busy(busy1));
    // N = 50, level, no retrigger
    dly_timer #(.DELAY_NS(1000), .EDGE_TRIG(0), .RETRIGGER(0)) u2 (
        .clk(clk), .reset(reset), .in(in2), .p(p2), .busy(busy2));
    // N = 10, edge mode
    dly_timer #(.DELAY_NS(200), .EDGE_TRIG(1), .RETRIGGER(1)) u3 (
        .clk(clk), .reset(reset), .in(in3), .p(p3), .busy(busy3));
    // N = 105000 (105 with DLY_FAST_SIM_EN)
    dly_timer #(.DELAY_NS(2_100_000), .EDGE_TRIG(0), .RETRIGGER(1)) u4 (
        .clk(clk), .reset(reset), .in(in4), .p(p4), .busy(busy4));

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        #2;
        reset = 1'b0;

        // Reset held for 3 cycles: everything idle.
        repeat (3) tick();
        chk("rst_p0", p0, 1'b0);       chk("rst_busy0", busy0, 1'b0);
        chk("rst_p1", p1, 1'b0);       chk("rst_busy1", busy1, 1'b0);
        chk("rst_p2", p2, 1'b0);       chk("rst_busy2", busy2, 1'b0);
        chk("rst_p3", p3, 1'b0);       chk("rst_busy3", busy3, 1'b0);
        chk("rst_p4", p4, 1'b0);       chk("rst_busy4", busy4, 1'b0);
        reset = 1'b1;

        // Quiet input for 50 cycles: no pulse.
        for (int k = 0; k < 50; k++) begin
            tick();
            chk("quiet_p0", p0, 1'b0);
            chk("quiet_busy0", busy0, 1'b0);
        end

        // Single one-cycle trigger at edge 0: p after edge 9, busy edges 0..9.
        for (int k = 0; k < 15; k++) begin
            in0 = (k == 0);
            tick();
            chk("single_p", p0, (k == 9));
            chk("single_busy", busy0, (k <= 9));
        end
        in0 = 1'b0;

        // Retrigger one edge before terminal: reload suppresses the pulse at 9.
        for (int k = 0; k < 23; k++) begin
            in0 = (k == 0) || (k == 9);
            tick();
            chk("retrig_p", p0, (k == 18));
            chk("retrig_busy", busy0, (k <= 18));
        end
        in0 = 1'b0;

        // Level held 20 cycles (last high sample edge 19): p after edge 68.
        for (int k = 0; k < 76; k++) begin
            in1 = (k < 20);
            tick();
            chk("level_p", p1, (k == 68));
            chk("level_busy", busy1, (k <= 68));
        end
        in1 = 1'b0;

        // No retrigger: triggers at 0 and 30 give one pulse; trigger at 60 another.
        for (int k = 0; k < 116; k++) begin
            in2 = (k == 0) || (k == 30) || (k == 60);
            tick();
            chk("noretrig_p", p2, (k == 49) || (k == 109));
            chk("noretrig_busy", busy2, (k <= 49) || ((k >= 60) && (k <= 109)));
        end
        in2 = 1'b0;

        // Edge mode: in held high 100 cycles fires exactly once.
        for (int k = 0; k < 105; k++) begin
            in3 = (k < 100);
            tick();
            chk("edge_p", p3, (k == 9));
            chk("edge_busy", busy3, (k <= 9));
        end
        in3 = 1'b0;

        // Long delay, reset asserted mid-run.
        for (int k = 0; k < 50000; k++) begin
            in4 = (k == 0);
            tick();
`ifdef DLY_FAST_SIM_EN
            chk("long_p", p4, (k == 104));
            chk("long_busy", busy4, (k <= 104));
`else
            chk("long_p", p4, 1'b0);
            chk("long_busy", busy4, 1'b1);
`endif
        end
        in4 = 1'b0;

        // Asynchronous reset: outputs clear without a clock edge.
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst_p4", p4, 1'b0);
        chk("async_rst_busy4", busy4, 1'b0);
        tick();
        reset = 1'b1;

        // Abandoned delay never produces a pulse after release.
        for (int k = 0; k < 200; k++) begin
            tick();
            chk("post_rst_p4", p4, 1'b0);
            chk("post_rst_busy4", busy4, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
